// File: rtl/mem_arb_pkg.sv
// Shared owner encoding, write FSM states and tie-break helper for mem_bus_arbiter.
// Build option MEM_ARB_DATA_PRIO_EN gives the data master every tie.
package mem_arb_pkg;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    typedef enum logic {
        W_IDLE,
        W_BUSY
    } wstate_e;

    function automatic logic pick(
        input logic req_i,
        input logic req_d,
        input logic tie
    );
        if (req_i && req_d) begin
            return tie;
        end else if (req_d) begin
            return OWNER_D;
        end
        return OWNER_I;
    endfunction

endpackage

// File: rtl/arb_owner_fifo.sv
// In-order FIFO of 1-bit read owner IDs; head selects the rdata destination.
// Option MEM_ARB_DATA_PRIO_EN does not affect this block.
module arb_owner_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  logic pop_i,
    input  logic din_i,
    output logic head_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    logic [DEPTH-1:0] mem_q;
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wptr_q] <= din_i;
                wptr_q <= wptr_q + PTR_ONE;
            end
            if (pop_i) begin
                rptr_q <= rptr_q + PTR_ONE;
            end
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head_o  = mem_q[rptr_q];
    assign full_o  = (cnt_q == CNT_FULL);
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between instruction and data masters (split read/write channels).
// Define MEM_ARB_DATA_PRIO_EN to make the data master win every tie.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int bus_width       = 32,
    parameter int max_outstanding = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_raddr_valid,
    input  logic                 i_waddr_valid,
    input  logic                 i_wdata_valid,
    input  logic                 i_rdata_ready,
    input  logic [bus_width-1:0] i_raddr,
    input  logic [bus_width-1:0] i_waddr,
    input  logic [bus_width-1:0] i_wdata,
    output logic                 i_raddr_ready,
    output logic                 i_waddr_ready,
    output logic                 i_wdata_ready,
    output logic                 i_rdata_valid,
    output logic [bus_width-1:0] i_rdata,
    input  logic                 d_raddr_valid,
    input  logic                 d_waddr_valid,
    input  logic                 d_wdata_valid,
    input  logic                 d_rdata_ready,
    input  logic [bus_width-1:0] d_raddr,
    input  logic [bus_width-1:0] d_waddr,
    input  logic [bus_width-1:0] d_wdata,
    output logic                 d_raddr_ready,
    output logic                 d_waddr_ready,
    output logic                 d_wdata_ready,
    output logic                 d_rdata_valid,
    output logic [bus_width-1:0] d_rdata,
    output logic                 m_raddr_valid,
    output logic                 m_waddr_valid,
    output logic                 m_wdata_valid,
    output logic                 m_rdata_ready,
    output logic [bus_width-1:0] m_raddr,
    output logic [bus_width-1:0] m_waddr,
    output logic [bus_width-1:0] m_wdata,
    input  logic                 m_raddr_ready,
    input  logic                 m_waddr_ready,
    input  logic                 m_wdata_ready,
    input  logic                 m_rdata_valid,
    input  logic [bus_width-1:0] m_rdata
);

    logic rd_lock_q, rd_lock_own_q, rd_tie, w_tie;
    logic rd_win, rd_wvalid, rd_open, rd_hs;
    logic f_head, f_full, f_empty, f_pop, hd_i, hd_d;
    wstate_e wst_q;
    logic wown_q, adone_q, ddone_q;
    logic w_busy, own_i, own_d, aw_hs, w_hs, w_req_i, w_req_d;

`ifdef MEM_ARB_DATA_PRIO_EN
    assign rd_tie = OWNER_D;
    assign w_tie  = OWNER_D;
`else
    logic rd_ptr_q, w_ptr_q;
    assign rd_tie = rd_ptr_q;
    assign w_tie  = w_ptr_q;
`endif

    // Read address: pass-through, grant pinned while a stalled request waits
    always_comb begin
        rd_win = rd_lock_q ? rd_lock_own_q
                           : pick(i_raddr_valid, d_raddr_valid, rd_tie);
        rd_wvalid = (rd_win == OWNER_D) ? d_raddr_valid : i_raddr_valid;
        rd_open = !rst && !f_full;
        m_raddr_valid = rd_open && rd_wvalid;
        m_raddr = (rd_win == OWNER_D) ? d_raddr : i_raddr;
        i_raddr_ready = rd_open && (rd_win == OWNER_I) && m_raddr_ready;
        d_raddr_ready = rd_open && (rd_win == OWNER_D) && m_raddr_ready;
        rd_hs = m_raddr_valid && m_raddr_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_lock_q     <= 1'b0;
            rd_lock_own_q <= OWNER_I;
`ifndef MEM_ARB_DATA_PRIO_EN
            rd_ptr_q      <= OWNER_I;
`endif
        end else begin
            rd_lock_q     <= rd_wvalid && !rd_hs;
            rd_lock_own_q <= rd_win;
`ifndef MEM_ARB_DATA_PRIO_EN
            if (rd_hs) begin
                rd_ptr_q <= ~rd_win;
            end
`endif
        end
    end

    arb_owner_fifo #(
        .DEPTH(max_outstanding)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (rd_hs),
        .pop_i  (f_pop),
        .din_i  (rd_win),
        .head_o (f_head),
        .full_o (f_full),
        .empty_o(f_empty)
    );

    always_comb begin
        hd_i = !rst && !f_empty && (f_head == OWNER_I);
        hd_d = !rst && !f_empty && (f_head == OWNER_D);
        i_rdata_valid = hd_i && m_rdata_valid;
        d_rdata_valid = hd_d && m_rdata_valid;
        m_rdata_ready = (hd_i && i_rdata_ready) || (hd_d && d_rdata_ready);
        f_pop = m_rdata_valid && m_rdata_ready;
    end

    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

    // Write channels are driven only from the latched owner while busy
    always_comb begin
        w_req_i = i_waddr_valid || i_wdata_valid;
        w_req_d = d_waddr_valid || d_wdata_valid;
        w_busy = !rst && (wst_q == W_BUSY);
        own_i = w_busy && (wown_q == OWNER_I);
        own_d = w_busy && (wown_q == OWNER_D);
        m_waddr_valid = !adone_q &&
                        ((own_i && i_waddr_valid) || (own_d && d_waddr_valid));
        m_wdata_valid = !ddone_q &&
                        ((own_i && i_wdata_valid) || (own_d && d_wdata_valid));
        m_waddr = (wown_q == OWNER_D) ? d_waddr : i_waddr;
        m_wdata = (wown_q == OWNER_D) ? d_wdata : i_wdata;
        i_waddr_ready = own_i && !adone_q && m_waddr_ready;
        d_waddr_ready = own_d && !adone_q && m_waddr_ready;
        i_wdata_ready = own_i && !ddone_q && m_wdata_ready;
        d_wdata_ready = own_d && !ddone_q && m_wdata_ready;
        aw_hs = m_waddr_valid && m_waddr_ready;
        w_hs = m_wdata_valid && m_wdata_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wst_q   <= W_IDLE;
            wown_q  <= OWNER_I;
            adone_q <= 1'b0;
            ddone_q <= 1'b0;
`ifndef MEM_ARB_DATA_PRIO_EN
            w_ptr_q <= OWNER_I;
`endif
        end else begin
            unique case (wst_q)
                W_IDLE: begin
                    if (w_req_i || w_req_d) begin
                        wst_q   <= W_BUSY;
                        wown_q  <= pick(w_req_i, w_req_d, w_tie);
                        adone_q <= 1'b0;
                        ddone_q <= 1'b0;
                    end
                end
                W_BUSY: begin
                    adone_q <= adone_q || aw_hs;
                    ddone_q <= ddone_q || w_hs;
                    if ((adone_q || aw_hs) && (ddone_q || w_hs)) begin
                        wst_q <= W_IDLE;
`ifndef MEM_ARB_DATA_PRIO_EN
                        w_ptr_q <= ~wown_q;
`endif
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: per-cycle reference model plus directed scenarios.
// Directed expectations assume MEM_ARB_DATA_PRIO_EN is undefined.
module tb_mem_bus_arbiter;

    localparam int BW = 32;
    localparam int MO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_raddr_valid, i_waddr_valid, i_wdata_valid, i_rdata_ready;
    logic [BW-1:0] i_raddr, i_waddr, i_wdata, i_rdata;
    logic i_raddr_ready, i_waddr_ready, i_wdata_ready, i_rdata_valid;
    logic d_raddr_valid, d_waddr_valid, d_wdata_valid, d_rdata_ready;
    logic [BW-1:0] d_raddr, d_waddr, d_wdata, d_rdata;
    logic d_raddr_ready, d_waddr_ready, d_wdata_ready, d_rdata_valid;
    logic m_raddr_valid, m_waddr_valid, m_wdata_valid, m_rdata_ready;
    logic [BW-1:0] m_raddr, m_waddr, m_wdata, m_rdata;
    logic m_raddr_ready, m_waddr_ready, m_wdata_ready, m_rdata_valid;

    int n_cmp = 0;
    int n_bad = 0;

    mem_bus_arbiter #(.bus_width(BW), .max_outstanding(MO)) dut (
        .clk(clk), .rst(rst),
        .i_raddr_valid(i_raddr_valid), .i_waddr_valid(i_waddr_valid),
        .i_wdata_valid(i_wdata_valid), .i_rdata_ready(i_rdata_ready),
        .i_raddr(i_raddr), .i_waddr(i_waddr), .i_wdata(i_wdata),
        .i_raddr_ready(i_raddr_ready), .i_waddr_ready(i_waddr_ready),
        .i_wdata_ready(i_wdata_ready), .i_rdata_valid(i_rdata_valid),
        .i_rdata(i_rdata),
        .d_raddr_valid(d_raddr_valid), .d_waddr_valid(d_waddr_valid),
        .d_wdata_valid(d_wdata_valid), .d_rdata_ready(d_rdata_ready),
        .d_raddr(d_raddr), .d_waddr(d_waddr), .d_wdata(d_wdata),
        .d_raddr_ready(d_raddr_ready), .d_waddr_ready(d_waddr_ready),
        .d_wdata_ready(d_wdata_ready), .d_rdata_valid(d_rdata_valid),
        .d_rdata(d_rdata),
        .m_raddr_valid(m_raddr_valid), .m_waddr_valid(m_waddr_valid),
        .m_wdata_valid(m_wdata_valid), .m_rdata_ready(m_rdata_ready),
        .m_raddr(m_raddr), .m_waddr(m_waddr), .m_wdata(m_wdata),
        .m_raddr_ready(m_raddr_ready), .m_waddr_ready(m_waddr_ready),
        .m_wdata_ready(m_wdata_ready), .m_rdata_valid(m_rdata_valid),
        .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [BW-1:0] act,
                       input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: owner queue, next-tie owner, stalled requester, write txn
    bit owners[$];
    bit rr_next = 0;
    int held = -1;
    bit wact = 0, wo = 0, asent = 0, dsent = 0, wrr = 0;
    bit full, g, gv, ev, hs, h, er, pop, ri, rq, eav, edv, tie, wtie;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            chk("rst_m_raddr_valid", m_raddr_valid, 0);
            chk("rst_i_raddr_ready", i_raddr_ready, 0);
            chk("rst_m_rdata_ready", m_rdata_ready, 0);
            chk("rst_m_waddr_valid", m_waddr_valid, 0);
            chk("rst_m_wdata_valid", m_wdata_valid, 0);
            chk("rst_i_rdata_valid", i_rdata_valid, 0);
            chk("rst_d_rdata_valid", d_rdata_valid, 0);
            owners.delete();
            rr_next = 0; held = -1; wact = 0; wrr = 0;
        end else begin
`ifdef MEM_ARB_DATA_PRIO_EN
            tie = 1; wtie = 1;
`else
            tie = rr_next; wtie = wrr;
`endif
            full = (owners.size() >= MO);
            if (held >= 0) g = held[0];
            else if (i_raddr_valid && d_raddr_valid) g = tie;
            else g = d_raddr_valid;
            gv = g ? d_raddr_valid : i_raddr_valid;
            ev = gv && !full;
            chk("m_raddr_valid", m_raddr_valid, ev);
            if (ev) chk("m_raddr", m_raddr, g ? d_raddr : i_raddr);
            if (i_raddr_valid)
                chk("i_raddr_ready", i_raddr_ready, !full && !g && m_raddr_ready);
            if (d_raddr_valid)
                chk("d_raddr_ready", d_raddr_ready, !full && g && m_raddr_ready);
            hs = ev && m_raddr_ready;

            pop = 0;
            if (owners.size() == 0) begin
                chk("empty_m_rdata_ready", m_rdata_ready, 0);
                chk("empty_i_rdata_valid", i_rdata_valid, 0);
                chk("empty_d_rdata_valid", d_rdata_valid, 0);
            end else begin
                h = owners[0];
                er = h ? d_rdata_ready : i_rdata_ready;
                chk("m_rdata_ready", m_rdata_ready, er);
                chk("i_rdata_valid", i_rdata_valid, !h && m_rdata_valid);
                chk("d_rdata_valid", d_rdata_valid, h && m_rdata_valid);
                if (m_rdata_valid) chk("rdata_route", h ? d_rdata : i_rdata, m_rdata);
                pop = m_rdata_valid && er;
            end

            if (!wact) begin
                chk("widle_m_waddr_valid", m_waddr_valid, 0);
                chk("widle_m_wdata_valid", m_wdata_valid, 0);
                chk("widle_i_waddr_ready", i_waddr_ready, 0);
                chk("widle_d_wdata_ready", d_wdata_ready, 0);
                ri = i_waddr_valid || i_wdata_valid;
                rq = d_waddr_valid || d_wdata_valid;
                if (ri || rq) begin
                    wact = 1; asent = 0; dsent = 0;
                    wo = (ri && rq) ? wtie : rq;
                end
            end else begin
                eav = (wo ? d_waddr_valid : i_waddr_valid) && !asent;
                edv = (wo ? d_wdata_valid : i_wdata_valid) && !dsent;
                chk("m_waddr_valid", m_waddr_valid, eav);
                chk("m_wdata_valid", m_wdata_valid, edv);
                if (eav) chk("m_waddr", m_waddr, wo ? d_waddr : i_waddr);
                if (edv) chk("m_wdata", m_wdata, wo ? d_wdata : i_wdata);
                chk("i_waddr_ready", i_waddr_ready, !wo && !asent && m_waddr_ready);
                chk("d_waddr_ready", d_waddr_ready, wo && !asent && m_waddr_ready);
                chk("i_wdata_ready", i_wdata_ready, !wo && !dsent && m_wdata_ready);
                chk("d_wdata_ready", d_wdata_ready, wo && !dsent && m_wdata_ready);
                asent = asent || (eav && m_waddr_ready);
                dsent = dsent || (edv && m_wdata_ready);
                if (asent && dsent) begin
                    wact = 0; wrr = !wo;
                end
            end

            if (pop) void'(owners.pop_front());
            if (hs) begin
                owners.push_back(g); rr_next = !g; held = -1;
            end else begin
                held = gv ? int'(g) : -1;
            end
        end
    end

    task automatic idle();
        i_raddr_valid = 0; i_waddr_valid = 0; i_wdata_valid = 0; i_rdata_ready = 0;
        d_raddr_valid = 0; d_waddr_valid = 0; d_wdata_valid = 0; d_rdata_ready = 0;
        i_raddr = '0; i_waddr = '0; i_wdata = '0;
        d_raddr = '0; d_waddr = '0; d_wdata = '0;
        m_raddr_ready = 0; m_waddr_ready = 0; m_wdata_ready = 0;
        m_rdata_valid = 0; m_rdata = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        i_raddr_valid = 1; d_waddr_valid = 1; m_raddr_ready = 1; m_rdata_valid = 1;
        repeat (3) @(posedge clk);
        #1;
        idle();
        rst = 0;
        #3;
        chk("reset_m_raddr_valid", m_raddr_valid, 0);
        chk("reset_m_rdata_ready", m_rdata_ready, 0);
        step();

        // Read ping-pong
        i_raddr_valid = 1; i_raddr = 32'h1000;
        d_raddr_valid = 1; d_raddr = 32'h2000;
        m_raddr_ready = 1;
        for (int k = 0; k < 4; k++) begin
            #3;
            chk("pp_grant", m_raddr, (k % 2 == 1) ? 32'h2000 : 32'h1000);
            step();
        end
        i_raddr_valid = 0; d_raddr_valid = 0;
        i_rdata_ready = 1; d_rdata_ready = 1; m_rdata_valid = 1;
        for (int k = 0; k < 4; k++) begin
            m_rdata = 32'hA + k;
            #3;
            chk("pp_i_rdata_valid", i_rdata_valid, (k % 2 == 0));
            chk("pp_d_rdata_valid", d_rdata_valid, (k % 2 == 1));
            chk("pp_rdata", (k % 2 == 1) ? d_rdata : i_rdata, 32'hA + k);
            step();
        end
        m_rdata_valid = 0;

        // Backpressure lock
        d_raddr_valid = 1; d_raddr = 32'h100; m_raddr_ready = 0;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                i_raddr_valid = 1; i_raddr = 32'h200;
            end
            #3;
            chk("bp_m_raddr", m_raddr, 32'h100);
            chk("bp_i_ready", i_raddr_ready, 0);
            step();
        end
        m_raddr_ready = 1;
        #3;
        chk("bp_hs_addr", m_raddr, 32'h100);
        chk("bp_hs_d_ready", d_raddr_ready, 1);
        chk("bp_hs_i_ready", i_raddr_ready, 0);
        step();
        d_raddr_valid = 0;
        #3;
        chk("bp_i_grant", m_raddr, 32'h200);
        chk("bp_i_ready_next", i_raddr_ready, 1);
        step();
        i_raddr_valid = 0; m_rdata_valid = 1;
        #3;
        chk("bp_ret_d", d_rdata_valid, 1);
        step();
        #3;
        chk("bp_ret_i", i_rdata_valid, 1);
        step();
        m_rdata_valid = 0;

        // FIFO full
        i_raddr_valid = 1; i_raddr = 32'h300; m_raddr_ready = 1;
        for (int k = 0; k < 4; k++) begin
            #3;
            chk("ff_accept", i_raddr_ready, 1);
            step();
        end
        #3;
        chk("ff_full_ready", i_raddr_ready, 0);
        chk("ff_full_valid", m_raddr_valid, 0);
        step();
        m_rdata_valid = 1; m_rdata = 32'h77;
        #3;
        chk("ff_pop_no_push", i_raddr_ready, 0);
        chk("ff_pop_valid", i_rdata_valid, 1);
        step();
        m_rdata_valid = 0;
        #3;
        chk("ff_fifth_accept", i_raddr_ready, 1);
        step();
        i_raddr_valid = 0; m_rdata_valid = 1;
        repeat (4) step();
        m_rdata_valid = 0;
        #3;
        chk("ff_drained", m_rdata_ready, 0);
        step();

        // Write lock and same-cycle completion
        m_waddr_ready = 1; m_wdata_ready = 1;
        d_waddr_valid = 1; d_waddr = 32'h20;
        #3;
        chk("wl_idle_latency", m_waddr_valid, 0);
        step();
        i_waddr_valid = 1; i_waddr = 32'h40; i_wdata_valid = 1; i_wdata = 32'h66;
        #3;
        chk("wl_d_addr", m_waddr, 32'h20);
        chk("wl_d_addr_ready", d_waddr_ready, 1);
        chk("wl_i_blocked1", i_waddr_ready, 0);
        step();
        d_waddr_valid = 0;
        #3;
        chk("wl_gap_valid", m_wdata_valid, 0);
        chk("wl_i_blocked2", i_waddr_ready, 0);
        step();
        d_wdata_valid = 1; d_wdata = 32'h55;
        #3;
        chk("wl_d_data", m_wdata, 32'h55);
        chk("wl_d_data_valid", m_wdata_valid, 1);
        chk("wl_i_blocked3", i_waddr_ready, 0);
        step();
        d_wdata_valid = 0;
        #3;
        chk("wl_idle2", m_waddr_valid, 0);
        step();
        #3;
        chk("sc_i_addr", m_waddr, 32'h40);
        chk("sc_i_data", m_wdata, 32'h66);
        chk("sc_i_addr_ready", i_waddr_ready, 1);
        chk("sc_i_data_ready", i_wdata_ready, 1);
        step();
        i_waddr = 32'h44; i_wdata = 32'h67;
        d_waddr_valid = 1; d_waddr = 32'h24; d_wdata_valid = 1; d_wdata = 32'h56;
        #3;
        chk("sc_back_idle", m_waddr_valid, 0);
        step();
        #3;
        chk("sc_ptr_d_addr", m_waddr, 32'h24);
        chk("sc_ptr_d_ready", d_waddr_ready, 1);
        chk("sc_ptr_i_ready", i_waddr_ready, 0);
        step();
        d_waddr_valid = 0; d_wdata_valid = 0;
        step();
        #3;
        chk("sc_i_second", m_waddr, 32'h44);
        step();
        i_waddr_valid = 0; i_wdata_valid = 0;
        m_waddr_ready = 0; m_wdata_ready = 0;
        step();

        // Reset with reads outstanding
        i_raddr_valid = 1; i_raddr = 32'h500; m_raddr_ready = 1;
        repeat (2) step();
        i_raddr_valid = 0;
        rst = 1;
        step();
        rst = 0;
        m_rdata_valid = 1; m_rdata = 32'hDEAD; i_rdata_ready = 1; d_rdata_ready = 1;
        #3;
        chk("rr_m_rdata_ready", m_rdata_ready, 0);
        chk("rr_i_rdata_valid", i_rdata_valid, 0);
        chk("rr_d_rdata_valid", d_rdata_valid, 0);
        step();
        idle();
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
